// File: rtl/loader_pkg.sv
// Shared types and constants for the MC14500B serial program loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Largest legal word count: one word per RAM location.
  function automatic logic [16:0] max_words(input int aw);
    return 17'(1) << aw;
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Modulo-256 byte accumulator; clear wins over add.
module loader_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sum <= 8'h00;
    else if (clr)    sum <= 8'h00;
    else if (add_en) sum <= sum + din;
  end

endmodule

// File: rtl/program_loader.sv
// Decodes SYNC/COUNT/words/CSUM frames from a byte stream into program RAM
// writes, holding the CPU in reset until a frame verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  prog_write,
  output logic [ADDR_WIDTH-1:0] prog_address,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  loader_state_t state, state_nxt;
  logic [7:0]  cnt_hi_q, data_hi_q, csum;
  logic [15:0] remaining, count_w, word_w;
  logic        accept, sync_acc, sum_add, wr_issue;

  assign accept  = rx_valid & rx_ready;
  assign count_w = {cnt_hi_q, rx_data};
  assign word_w  = {data_hi_q, rx_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE, DONE, ERROR: if (rx_data == SYNC_BYTE) state_nxt = CNT_HI;
        CNT_HI:  state_nxt = CNT_LO;
        CNT_LO: begin
          if (count_w == 16'd0)                              state_nxt = CHECK;
          else if ({1'b0, count_w} > max_words(ADDR_WIDTH)) state_nxt = ERROR;
          else                                               state_nxt = DATA_HI;
        end
        DATA_HI: state_nxt = DATA_LO;
        DATA_LO: state_nxt = (remaining == 16'd1) ? CHECK : DATA_HI;
        CHECK:   state_nxt = (rx_data == csum) ? DONE : ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    done     = (state == DONE);
    error    = (state == ERROR);
    cpu_hold = (state != DONE);
    sync_acc = accept && (rx_data == SYNC_BYTE) &&
               (state == IDLE || state == DONE || state == ERROR);
    sum_add  = accept && (state == DATA_HI || state == DATA_LO);
    wr_issue = accept && (state == DATA_LO);
  end

  loader_checksum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr    (sync_acc),
    .add_en (sum_add),
    .din    (rx_data),
    .sum    (csum)
  );

  // Address advances on the write strobe itself, so the strobe cycle sees
  // the address of the word being written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready     <= 1'b0;
      prog_write   <= 1'b0;
      prog_address <= '0;
      prog_data    <= '0;
      cnt_hi_q     <= 8'h00;
      data_hi_q    <= 8'h00;
      remaining    <= 16'd0;
    end else begin
      rx_ready   <= 1'b1;
      prog_write <= wr_issue;
      if (sync_acc)        prog_address <= '0;
      else if (prog_write) prog_address <= prog_address + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (sync_acc) begin
        cnt_hi_q  <= 8'h00;
        remaining <= 16'd0;
      end
      if (accept && state == CNT_HI)  cnt_hi_q  <= rx_data;
      if (accept && state == CNT_LO)  remaining <= count_w;
      if (accept && state == DATA_HI) data_hi_q <= rx_data;
      if (wr_issue) begin
        prog_data <= word_w[DATA_WIDTH-1:0];
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule
